// File: rtl/data_mem_responder_if.sv
// Data-port request/response bundle between the memory stage and the
// data memory responder, plus the memory-mapped IO bus it forwards to.
interface data_mem_responder_if;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_DIN;
    logic        REQ_WE;
    logic        REQ_RDEN;
    logic [2:0]  REQ_SIZE;
    logic        REQ_STALL;
    logic [31:0] RSP_DOUT;
    logic        RSP_VALID;
    logic        RSP_ERR;
    logic [31:0] IO_ADDR;
    logic [31:0] IO_OUT;
    logic        IO_WR;
    logic        IO_RD;
    logic [31:0] IO_IN;

    // Responder side
    modport slave (
        input  REQ_ADDR, REQ_DIN, REQ_WE, REQ_RDEN, REQ_SIZE, IO_IN,
        output REQ_STALL, RSP_DOUT, RSP_VALID, RSP_ERR,
        output IO_ADDR, IO_OUT, IO_WR, IO_RD
    );

    // Requester side
    modport master (
        output REQ_ADDR, REQ_DIN, REQ_WE, REQ_RDEN, REQ_SIZE, IO_IN,
        input  REQ_STALL, RSP_DOUT, RSP_VALID, RSP_ERR,
        input  IO_ADDR, IO_OUT, IO_WR, IO_RD
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: services byte/half/word loads and stores from a
// word-organised RAM or the memory-mapped IO bus. Word-crossing RAM
// accesses take a second cycle (SPLIT) during which the requester stalls.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
    input  logic                  MEM_CLOCK,
    input  logic                  MEM_RESET_N,
    data_mem_responder_if.slave   bus
);
    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];

    // Request decode
    logic [1:0]    off;
    logic [1:0]    io_off;
    logic [2:0]    nbytes;
    logic [3:0]    base_mask;
    logic          illegal;
    logic          is_io;
    logic          ram_oor;
    logic          req;
    logic          is_store;
    logic          is_load;
    logic          ram_ok;
    logic          do_split;
    logic          err_now;
    logic          hi_ok;
    logic          wr_lo_en;
    logic          wr_hi_en;
    logic [31:0]   word_p1;
    logic [AW-1:0] w_idx;
    logic [7:0]    wmask;
    logic [63:0]   wdata;
    logic [31:0]   ram_word;
    logic [31:0]   hi_word;
    logic [31:0]   load_raw;
    logic [31:0]   split_raw;

    // Context of a split access, held across the SPLIT cycle
    logic [AW-1:0] s_hi_idx;
    logic          s_hi_ok;
    logic          s_we;
    logic          s_rd;
    logic [1:0]    s_off;
    logic [2:0]    s_size;
    logic [3:0]    s_mask;
    logic [31:0]   s_data;
    logic [31:0]   s_lo;

    function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [2:0] size);
        logic [31:0] r;
        case (size[1:0])
            2'b00:   r = size[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   r = size[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Decode the presented request and drive the combinational strobes
    always_comb begin
        off       = bus.REQ_ADDR[1:0];
        illegal   = (bus.REQ_SIZE[1:0] == 2'b11) || (bus.REQ_SIZE[2] && bus.REQ_SIZE[1]);
        case (bus.REQ_SIZE[1:0])
            2'b00:   begin nbytes = 3'd1; base_mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; base_mask = 4'b0011; end
            default: begin nbytes = 3'd4; base_mask = 4'b1111; end
        endcase
        io_off    = (bus.REQ_SIZE[1:0] == 2'b10) ? 2'b00 : off;
        is_io     = bus.REQ_ADDR >= IO_BASE;
        ram_oor   = !is_io && ({1'b0, bus.REQ_ADDR} >= RAM_BYTES);
        // A new request is only decoded outside SPLIT and out of reset
        req       = MEM_RESET_N && (state != SPLIT) && (bus.REQ_WE || bus.REQ_RDEN);
        is_store  = req && bus.REQ_WE;
        is_load   = req && bus.REQ_RDEN && !bus.REQ_WE;
        ram_ok    = req && !illegal && !is_io && !ram_oor;
        do_split  = ram_ok && (({1'b0, off} + nbytes) > 3'd4);
        err_now   = req && (illegal || ram_oor || (bus.REQ_WE && bus.REQ_RDEN) ||
                            (is_io && (bus.REQ_SIZE == 3'b010) && (off != 2'b00)));
        word_p1   = {2'b00, bus.REQ_ADDR[31:2]} + 32'd1;
        hi_ok     = word_p1 < DEPTH_WORDS;
        w_idx     = bus.REQ_ADDR[AW+1:2];
        wmask     = {4'b0000, base_mask} << off;
        wdata     = {32'h0, bus.REQ_DIN} << {off, 3'b000};
        wr_lo_en  = is_store && ram_ok;
        wr_hi_en  = MEM_RESET_N && (state == SPLIT) && s_we && s_hi_ok;
        ram_word  = mem[w_idx];
        hi_word   = s_hi_ok ? mem[s_hi_idx] : '0;
        load_raw  = is_io ? (bus.IO_IN >> {io_off, 3'b000}) : (ram_word >> {off, 3'b000});
        split_raw = 32'({hi_word, s_lo} >> {s_off, 3'b000});

        bus.REQ_STALL = MEM_RESET_N && ((state == SPLIT) || do_split);
        bus.IO_ADDR   = bus.REQ_ADDR;
        bus.IO_OUT    = bus.REQ_DIN;
        bus.IO_WR     = is_store && is_io && !illegal;
        bus.IO_RD     = is_load && is_io && !illegal;
    end

    // Byte-enabled RAM writes: low word in the issue cycle, high word in SPLIT
    always_ff @(posedge MEM_CLOCK) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_lo_en && wmask[i])
                mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            if (wr_hi_en && s_mask[i])
                mem[s_hi_idx][8*i +: 8] <= s_data[8*i +: 8];
        end
    end

    // Capture the split context and the low word as the split is issued
    always_ff @(posedge MEM_CLOCK) begin
        if (do_split) begin
            s_hi_idx <= w_idx + AW'(1);
            s_hi_ok  <= hi_ok;
            s_we     <= is_store;
            s_rd     <= is_load;
            s_off    <= off;
            s_size   <= bus.REQ_SIZE;
            s_mask   <= wmask[7:4];
            s_data   <= wdata[63:32];
            s_lo     <= ram_word;
        end
    end

    // Control FSM with registered response outputs; RESP decodes like IDLE
    always_ff @(posedge MEM_CLOCK) begin
        if (!MEM_RESET_N) begin
            state         <= IDLE;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_DOUT  <= '0;
            bus.RSP_ERR   <= 1'b0;
        end else if (state == SPLIT) begin
            state         <= RESP;
            bus.RSP_VALID <= s_rd;
            bus.RSP_ERR   <= !s_hi_ok;
            if (s_rd)
                bus.RSP_DOUT <= fmt_load(split_raw, s_size);
        end else begin
            state         <= do_split ? SPLIT : IDLE;
            bus.RSP_VALID <= is_load && !do_split;
            bus.RSP_ERR   <= err_now;
            if (is_load && !do_split)
                bus.RSP_DOUT <= (illegal || ram_oor) ? '0 : fmt_load(load_raw, bus.REQ_SIZE);
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;
    localparam int unsigned DEPTH     = 16384;
    localparam int unsigned RAM_BYTES = DEPTH * 4;
    localparam logic [31:0] IOB       = 32'h1100_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .IO_BASE     (IOB)
    ) dut (
        .MEM_CLOCK   (clk),
        .MEM_RESET_N (rst_n),
        .bus         (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        chk_en = 1'b0;

    // Model state
    logic [7:0]  mb [RAM_BYTES];
    logic        exp_stall = 0, exp_iowr = 0, exp_iord = 0, exp_valid = 0, exp_err = 0;
    logic [31:0] exp_dout = 0, exp_ioaddr = 0, exp_ioout = 0;
    logic        nxt_valid = 0, nxt_err = 0;
    logic [31:0] nxt_dout = 0;
    logic        sp_pending = 0, sp_load = 0, sp_err = 0;
    logic [31:0] sp_dout = 0;
    logic [31:0] sp_ba [4];
    logic [7:0]  sp_bv [4];
    int unsigned sp_n = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] m_fmt(input logic [31:0] v, input logic [2:0] sz);
        case (sz)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return {24'd0, v[7:0]};
            3'd5:    return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Drive one cycle of requester inputs and work out what the DUT owes
    task automatic step(input logic rn, input logic we, input logic rd, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] ioi);
        int unsigned off, nb, ba;
        logic [31:0] val;
        logic        hi_oor, ill, ld;
        exp_valid = nxt_valid;
        exp_err   = nxt_err;
        exp_dout  = nxt_dout;
        nxt_valid = 0;
        nxt_err   = 0;
        nxt_dout  = 0;
        exp_stall = 0;
        exp_iowr  = 0;
        exp_iord  = 0;
        rst_n        = rn;
        bus.REQ_WE   = we;
        bus.REQ_RDEN = rd;
        bus.REQ_SIZE = sz;
        bus.REQ_ADDR = a;
        bus.REQ_DIN  = d;
        bus.IO_IN    = ioi;
        exp_ioaddr   = a;
        exp_ioout    = d;
        ld  = rd && !we;
        off = 32'(a[1:0]);
        nb  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        ill = (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7);
        if (!rn) begin
            sp_pending = 0;
        end else if (sp_pending) begin
            exp_stall = 1;
            for (int unsigned i = 0; i < sp_n; i++) mb[sp_ba[i]] = sp_bv[i];
            nxt_valid  = sp_load;
            nxt_dout   = sp_dout;
            nxt_err    = sp_err;
            sp_pending = 0;
        end else if (we || rd) begin
            if (ill) begin
                nxt_err   = 1;
                nxt_valid = ld;
            end else if (a >= IOB) begin
                exp_iowr = we;
                exp_iord = ld;
                nxt_err  = (we && rd) || (sz == 3'd2 && off != 0);
                if (ld) begin
                    nxt_valid = 1;
                    nxt_dout  = m_fmt((sz == 3'd2) ? ioi : (ioi >> (8 * off)), sz);
                end
            end else if (a >= RAM_BYTES) begin
                nxt_err   = 1;
                nxt_valid = ld;
            end else begin
                val    = 0;
                hi_oor = 0;
                sp_n   = 0;
                for (int unsigned k = 0; k < nb; k++) begin
                    ba = a + k;
                    if (ba >= RAM_BYTES) hi_oor = 1;
                    else if (we) begin
                        if (off + k < 4) mb[ba] = d[8*k +: 8];
                        else begin
                            sp_ba[sp_n] = ba;
                            sp_bv[sp_n] = d[8*k +: 8];
                            sp_n++;
                        end
                    end else val = val | (32'(mb[ba]) << (8 * k));
                end
                nxt_err = we && rd;
                if (off + nb > 4) begin
                    exp_stall  = 1;
                    sp_pending = 1;
                    sp_load    = ld;
                    sp_dout    = m_fmt(val, sz);
                    sp_err     = hi_oor;
                end else begin
                    nxt_valid = ld;
                    nxt_dout  = m_fmt(val, sz);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 3'd2, 32'h0, 32'h0, 32'h0);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(bus.REQ_STALL), 32'(exp_stall));
            check("io_wr", 32'(bus.IO_WR), 32'(exp_iowr));
            check("io_rd", 32'(bus.IO_RD), 32'(exp_iord));
            check("rsp_valid", 32'(bus.RSP_VALID), 32'(exp_valid));
            check("rsp_err", 32'(bus.RSP_ERR), 32'(exp_err));
            check("io_addr", bus.IO_ADDR, exp_ioaddr);
            check("io_out", bus.IO_OUT, exp_ioout);
            if (exp_valid) check("rsp_dout", bus.RSP_DOUT, exp_dout);
        end
    end

    logic [2:0] sz_tab [16];

    initial begin
        logic [31:0] a, d, ioi;
        logic [2:0]  sz;
        logic        we, rd;
        int unsigned r, kind;
        bus.REQ_WE = 0; bus.REQ_RDEN = 0; bus.REQ_SIZE = 3'd2;
        bus.REQ_ADDR = 0; bus.REQ_DIN = 0; bus.IO_IN = 0;
        sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2,
                   3'd4, 3'd5, 3'd1, 3'd2, 3'd0, 3'd3, 3'd6, 3'd7};
        @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_valid", 32'(bus.RSP_VALID), 32'h0);
        check("reset_err", 32'(bus.RSP_ERR), 32'h0);
        check("reset_dout", bus.RSP_DOUT, 32'h0);
        step(0, 0, 0, 3'd2, 32'h0, 32'h0, 32'h0);

        // Give the exercised RAM windows known contents
        for (int unsigned w = 0; w < 512; w++) step(1, 1, 0, 3'd2, w * 4, 32'h0, 32'h0);
        for (int unsigned w = DEPTH - 4; w < DEPTH; w++) step(1, 1, 0, 3'd2, w * 4, 32'h0, 32'h0);

        // Aligned word store then load
        step(1, 1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 0);
        step(1, 0, 1, 3'd2, 32'h100, 0, 0);
        check("lw_100", bus.RSP_DOUT, 32'hDEADBEEF);
        check("lw_100_valid", 32'(bus.RSP_VALID), 32'h1);

        // Byte store, signed/unsigned extraction
        step(1, 1, 0, 3'd0, 32'h203, 32'h80, 0);
        step(1, 0, 1, 3'd0, 32'h203, 0, 0);
        check("lb_203", bus.RSP_DOUT, 32'hFFFFFF80);
        step(1, 0, 1, 3'd4, 32'h203, 0, 0);
        check("lbu_203", bus.RSP_DOUT, 32'h00000080);
        step(1, 0, 1, 3'd5, 32'h202, 0, 0);
        check("lhu_202", bus.RSP_DOUT, 32'h00008000);

        // Split word store and load
        step(1, 1, 0, 3'd2, 32'h102, 32'h11223344, 0);
        check("split_stall", 32'(bus.REQ_STALL), 32'h1);
        step(1, 1, 0, 3'd2, 32'h102, 32'h11223344, 0);
        step(1, 0, 1, 3'd2, 32'h100, 0, 0);
        check("lw_100_after_split", bus.RSP_DOUT, 32'h3344BEEF);
        step(1, 0, 1, 3'd2, 32'h104, 0, 0);
        check("lw_104_after_split", bus.RSP_DOUT, 32'h00001122);
        step(1, 0, 1, 3'd2, 32'h102, 0, 0);
        check("split_lw_wait", 32'(bus.RSP_VALID), 32'h0);
        step(1, 0, 1, 3'd2, 32'h102, 0, 0);
        check("split_lw_102", bus.RSP_DOUT, 32'h11223344);
        check("split_lw_valid", 32'(bus.RSP_VALID), 32'h1);

        // IO store and loads
        step(1, 1, 0, 3'd2, 32'h1100_0004, 32'h5A, 0);
        step(1, 0, 1, 3'd2, 32'h100, 0, 0);
        check("ram_after_io_sw", bus.RSP_DOUT, 32'h3344BEEF);
        step(1, 0, 1, 3'd2, 32'h1100_0000, 0, 32'hCAFE0001);
        check("io_lw", bus.RSP_DOUT, 32'hCAFE0001);
        step(1, 0, 1, 3'd2, 32'h1100_0002, 0, 32'h12345678);
        check("io_lw_misaligned", bus.RSP_DOUT, 32'h12345678);
        check("io_lw_misaligned_err", 32'(bus.RSP_ERR), 32'h1);

        // Reset in the SPLIT cycle abandons the high half
        step(1, 1, 0, 3'd2, 32'h3FE, 32'hA1B2C3D4, 0);
        step(0, 0, 0, 3'd2, 32'h0, 0, 0);
        idle();
        check("post_reset_valid", 32'(bus.RSP_VALID), 32'h0);
        check("post_reset_err", 32'(bus.RSP_ERR), 32'h0);
        check("post_reset_stall", 32'(bus.REQ_STALL), 32'h0);
        step(1, 0, 1, 3'd2, 32'h3FC, 0, 0);
        check("lw_3fc", bus.RSP_DOUT, 32'hC3D40000);
        step(1, 0, 1, 3'd2, 32'h400, 0, 0);
        check("lw_400", bus.RSP_DOUT, 32'h00000000);

        // WE and RDEN together, then illegal size
        step(1, 1, 1, 3'd2, 32'h10, 32'h12345678, 0);
        check("we_rd_err", 32'(bus.RSP_ERR), 32'h1);
        check("we_rd_novalid", 32'(bus.RSP_VALID), 32'h0);
        step(1, 0, 1, 3'd2, 32'h10, 0, 0);
        check("lw_10", bus.RSP_DOUT, 32'h12345678);
        step(1, 0, 1, 3'd3, 32'h20, 0, 0);
        check("illegal_err", 32'(bus.RSP_ERR), 32'h1);
        check("illegal_valid", 32'(bus.RSP_VALID), 32'h1);
        check("illegal_dout", bus.RSP_DOUT, 32'h0);

        // Split store whose high word is past the end of RAM
        step(1, 1, 0, 3'd2, 32'hFFFE, 32'h55667788, 0);
        step(1, 1, 0, 3'd2, 32'hFFFE, 32'h55667788, 0);
        check("hi_oor_err", 32'(bus.RSP_ERR), 32'h1);
        step(1, 0, 1, 3'd2, 32'hFFFC, 0, 0);
        check("lw_fffc", bus.RSP_DOUT, 32'h77880000);
        step(1, 0, 1, 3'd2, 32'h0002_0000, 0, 0);
        check("ram_oor_dout", bus.RSP_DOUT, 32'h0);
        check("ram_oor_err", 32'(bus.RSP_ERR), 32'h1);

        // Randomized traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = $urandom_range(0, 32'h7F0);
            else if (r < 78) a = 32'hFFF0 + $urandom_range(0, 15);
            else if (r < 85) a = 32'h0001_0000 + $urandom_range(0, 32'h00FF_FFFF);
            else             a = IOB + $urandom_range(0, 255);
            sz   = sz_tab[$urandom_range(0, 15)];
            kind = $urandom_range(0, 15);
            we   = (kind >= 1) && (kind <= 8);
            rd   = (kind == 1) || (kind > 8);
            if (a >= IOB && sz[1:0] == 2'b01) a[0] = 1'b0;
            d   = $urandom;
            ioi = $urandom;
            step(($urandom_range(0, 63) != 0), we, rd, sz, a, d, ioi);
        end
        for (int unsigned n = 0; n < 4; n++) idle();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
